sprite_color_index_gen: RTL
===========================

Name: sprite_color_index_gen

Overview:
- Per-pixel colour-index generator for one animated sprite. It sits directly upstream of the colour-lookup stage.
- Takes the VGA raster position (DrawX/DrawY) and looks up the sprite's index in an external synchronous sprite ROM.
- Outputs a palette index (0 = background … 8 = light red) that the colour-lookup stage converts to R/G/B.
- Also owns the sprite position double-buffering and the animation-frame sequencing.

Parameters:
- SPR_W, 32, sprite width in pixels (power of two).
- SPR_H, 32, sprite height in pixels.
- NUM_ANIM, 4, number of animation frames stored back-to-back in ROM.
- FRAMES_PER_ANIM, 8, video frames each animation frame is shown.
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_H*NUM_ANIM.
- IDX_W, 4, palette index width.

Ports:
- Clk, in, 1: pixel-domain clock.
- Reset, in, 1: synchronous, active-high reset.
- frame_start, in, 1: one-cycle pulse at the start of vertical blank.
- pos_valid, in, 1: load request for a new sprite position.
- sprite_x, in, 10: requested top-left X, in pixels.
- sprite_y, in, 10: requested top-left Y, in pixels.
- pixel_valid, in, 1: high during the active display region.
- DrawX, in, 10: current raster X (0..639).
- DrawY, in, 10: current raster Y (0..479).
- rom_addr, out, ADDR_W: address to the sprite ROM (ROM output is registered, 1-cycle read latency).
- rom_data, in, IDX_W: palette index returned by the ROM.
- color_idx, out, IDX_W: palette index for the colour-lookup stage.
- color_valid, out, 1: color_idx corresponds to an active pixel.

Behaviour:
- Reset values: rom_addr 0, color_idx 1 (black), color_valid 0. All pipeline valid and hit flags are 0. Pending and active positions are (0,0). Animation frame is 0 and the frame counter is 0.
- Position double-buffer:
  - pos_valid loads sprite_x/y into the pending registers. The last write before frame_start wins.
  - On frame_start, pending is copied to active.
  - If pos_valid and frame_start coincide, the incoming sprite_x/y go straight to active and also update pending.
  - Active never changes mid-frame.
- Animation:
  - The frame counter increments on each frame_start.
  - When it reaches FRAMES_PER_ANIM-1, the next frame_start clears it and advances anim = (anim+1) mod NUM_ANIM. anim wraps NUM_ANIM-1 → 0.
- Pipeline: 3 stages, with fixed latency of exactly 3 rising edges from sampling DrawX/DrawY/pixel_valid to the corresponding color_idx/color_valid.
  - S1 (edge 1):
    - hit = pixel_valid & DrawX ≥ ax & DrawX < ax+SPR_W & DrawY ≥ ay & DrawY < ay+SPR_H.
    - Comparisons are done in 11 bits; there is no wrap-around. A sprite overhanging the right or bottom edge is clipped, and ax ≥ 640 never hits.
    - rom_addr = anim*SPR_W*SPR_H + (DrawY−ay)*SPR_W + (DrawX−ax) on a hit, and is held at its previous value otherwise.
    - pixel_valid and hit are registered.
  - S2 (edge 2): ROM presents data; valid/hit are delayed.
  - S3 (edge 3): color_valid = delayed pixel_valid. color_idx is then:
    - 1 if pixel_valid = 0 (blanking is black);
    - otherwise 0 on a miss;
    - otherwise 0 if rom_data == 0 (transparent);
    - otherwise rom_data.
- frame_start arriving during the active region is legal. Pixels already in flight keep their old address; pixels sampled on or after the update edge use the new position and animation frame.
- Reset asserted mid-line: all stages flush to reset values on that edge. Output is black/invalid for 3 cycles after release, with no stale hit.
- Back-to-back pixels are accepted every cycle; there is no stall.

Decomposition:
- Package sprite_pkg holds:
  - palette constants: COLOR_BG=0, COLOR_BLACK=1, COLOR_PINK=2, COLOR_GREY=3, COLOR_GREEN=4, COLOR_WHITE=5, COLOR_DKRED=6, COLOR_RED=7, COLOR_LTRED=8;
  - IDX_W;
  - SCREEN_W=640 and SCREEN_H=480.
- One sub-module, sprite_anim_counter, holds the frame counter and anim register. Its inputs are frame_start and Reset; its output is anim.

Test Plan:
- Reset, then pos (100,50) with frame_start, then raster (100,50) with pixel_valid and rom_data=4 → rom_addr=0 after 1 edge; color_idx=4 and color_valid=1 exactly 3 edges after sampling.
- Same sprite, raster (131,50) then (132,50) → first gives rom_addr=31 with a hit; second is a miss with color_idx=0. Raster (99,50) also → 0.
- rom_data=0 inside the sprite → color_idx=0. pixel_valid=0 → color_idx=1, color_valid=0.
- pos_valid (620,470) mid-frame → position unchanged until frame_start. Afterwards (639,479) hits with addr 9*32+19=307 and (0,0) misses. Coincident pos_valid+frame_start takes effect immediately.
- 8 frame_starts → anim=1, and pixel (100,50) gives rom_addr=1024. After 32 frame_starts anim wraps to 0.
- Reset asserted while hits are in flight → color_idx=1, color_valid=0 for the next 3 edges; anim and position return to 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite colour-index path: palette indices,
// index width and visible screen size.
package sprite_pkg;

    localparam int IDX_W = 4;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Palette indices understood by the downstream colour-lookup stage
    localparam int COLOR_BG    = 0;
    localparam int COLOR_BLACK = 1;
    localparam int COLOR_PINK  = 2;
    localparam int COLOR_GREY  = 3;
    localparam int COLOR_GREEN = 4;
    localparam int COLOR_WHITE = 5;
    localparam int COLOR_DKRED = 6;
    localparam int COLOR_RED   = 7;
    localparam int COLOR_LTRED = 8;

    // True when p lies in [lo, lo+len). Operands are 11 bits wide so a
    // 10-bit start plus a sprite dimension never wraps around.
    function automatic logic in_span(input logic [10:0] p,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (p >= lo) && (p < (lo + len));
    endfunction

endpackage

// File: rtl/sprite_anim_counter.sv
// Animation sequencer: counts video frames and steps the animation frame
// once every FRAMES_PER_ANIM frame_start pulses, wrapping after NUM_ANIM.
module sprite_anim_counter
    import sprite_pkg::*;
#(
    parameter int FRAMES_PER_ANIM = 8,
    parameter int NUM_ANIM        = 4,
    parameter int ANIM_W          = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    output logic [ANIM_W-1:0] anim
);

    localparam int CNT_W = (FRAMES_PER_ANIM > 1) ? $clog2(FRAMES_PER_ANIM) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAMES_PER_ANIM - 1);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(NUM_ANIM - 1);

    logic [CNT_W-1:0]  frame_cnt_reg;
    logic [ANIM_W-1:0] anim_reg;

    // Frame counter and animation index, both advanced only by frame_start
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_reg <= '0;
            anim_reg      <= '0;
        end else if (frame_start) begin
            if (frame_cnt_reg == CNT_LAST) begin
                frame_cnt_reg <= '0;
                anim_reg      <= (anim_reg == ANIM_LAST) ? '0 : anim_reg + ANIM_W'(1);
            end else begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign anim = anim_reg;

endmodule

// File: rtl/sprite_color_index_gen.sv
// Per-pixel palette-index generator for one animated sprite. Tracks a
// double-buffered sprite position, derives the sprite ROM address from the
// raster position and turns the ROM result into a palette index three
// clock edges after the raster position was sampled.
module sprite_color_index_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int NUM_ANIM        = 4,
    parameter int FRAMES_PER_ANIM = 8,
    parameter int ADDR_W          = 12,
    parameter int IDX_W           = sprite_pkg::IDX_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              pos_valid,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              pixel_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_data,
    output logic [IDX_W-1:0]  color_idx,
    output logic              color_valid
);

    localparam int ANIM_W     = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1;
    localparam int FRAME_SZ   = SPR_W * SPR_H;
    // Stages holding valid/hit before the output stage (S1 and S2)
    localparam int PIPE_DEPTH = 2;

    // ------------------------------------------------------------------
    // Position double-buffer
    // ------------------------------------------------------------------
    logic [9:0] pend_x_reg, pend_y_reg;
    logic [9:0] act_x_reg,  act_y_reg;

    // Pending takes every load; active only changes on frame_start, and a
    // load coinciding with frame_start goes straight through to active.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_x_reg <= '0;
            pend_y_reg <= '0;
            act_x_reg  <= '0;
            act_y_reg  <= '0;
        end else begin
            if (pos_valid) begin
                pend_x_reg <= sprite_x;
                pend_y_reg <= sprite_y;
            end
            if (frame_start) begin
                act_x_reg <= pos_valid ? sprite_x : pend_x_reg;
                act_y_reg <= pos_valid ? sprite_y : pend_y_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Animation frame sequencing
    // ------------------------------------------------------------------
    logic [ANIM_W-1:0] anim;

    sprite_anim_counter #(
        .FRAMES_PER_ANIM (FRAMES_PER_ANIM),
        .NUM_ANIM        (NUM_ANIM),
        .ANIM_W          (ANIM_W)
    ) u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .anim        (anim)
    );

    // ------------------------------------------------------------------
    // S1: hit test and ROM address
    // ------------------------------------------------------------------
    logic [10:0]       draw_x_ext, draw_y_ext;
    logic [10:0]       act_x_ext,  act_y_ext;
    logic [10:0]       x_off,      y_off;
    logic              hit_s1;
    logic [ADDR_W-1:0] addr_calc;

    // Hit detection and in-sprite offset; 11-bit arithmetic means a sprite
    // hanging past the right/bottom edge is simply clipped.
    always_comb begin
        draw_x_ext = {1'b0, DrawX};
        draw_y_ext = {1'b0, DrawY};
        act_x_ext  = {1'b0, act_x_reg};
        act_y_ext  = {1'b0, act_y_reg};
        x_off      = draw_x_ext - act_x_ext;
        y_off      = draw_y_ext - act_y_ext;
        hit_s1     = pixel_valid
                   & in_span(draw_x_ext, act_x_ext, 11'(SPR_W))
                   & in_span(draw_y_ext, act_y_ext, 11'(SPR_H));
        addr_calc  = ADDR_W'(anim) * ADDR_W'(FRAME_SZ)
                   + ADDR_W'(y_off) * ADDR_W'(SPR_W)
                   + ADDR_W'(x_off);
    end

    logic [ADDR_W-1:0] rom_addr_reg;
    logic              valid_pipe [PIPE_DEPTH];
    logic              hit_pipe   [PIPE_DEPTH];

    // ROM address register: only hits move it, misses hold the last address
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_reg <= '0;
        end else if (hit_s1) begin
            rom_addr_reg <= addr_calc;
        end
    end

    // First stage of the valid/hit delay line
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_pipe[0] <= 1'b0;
            hit_pipe[0]   <= 1'b0;
        end else begin
            valid_pipe[0] <= pixel_valid;
            hit_pipe[0]   <= hit_s1;
        end
    end

    // ------------------------------------------------------------------
    // S2: flags follow the ROM read latency
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 1; gi < PIPE_DEPTH; gi++) begin : g_flag_delay
            // Delay valid/hit one more cycle to line up with rom_data
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    valid_pipe[gi] <= 1'b0;
                    hit_pipe[gi]   <= 1'b0;
                end else begin
                    valid_pipe[gi] <= valid_pipe[gi-1];
                    hit_pipe[gi]   <= hit_pipe[gi-1];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // S3: palette index
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] color_next;

    // Blanking is black, misses and transparent texels are background
    always_comb begin
        color_next = IDX_W'(COLOR_BG);
        if (!valid_pipe[PIPE_DEPTH-1]) begin
            color_next = IDX_W'(COLOR_BLACK);
        end else if (hit_pipe[PIPE_DEPTH-1] && (rom_data != '0)) begin
            color_next = rom_data;
        end
    end

    logic [IDX_W-1:0] color_idx_reg;
    logic             color_valid_reg;

    // Output register facing the colour-lookup stage
    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_idx_reg   <= IDX_W'(COLOR_BLACK);
            color_valid_reg <= 1'b0;
        end else begin
            color_idx_reg   <= color_next;
            color_valid_reg <= valid_pipe[PIPE_DEPTH-1];
        end
    end

    assign rom_addr    = rom_addr_reg;
    assign color_idx   = color_idx_reg;
    assign color_valid = color_valid_reg;

endmodule
